// File: rtl/pipeline_types.sv
// Shared pipeline types: decoded-instruction entry and instruction-queue sizing.
package pipeline_types;

  localparam int DECODER_WIDTH = 2;
  localparam int ISSUE_WIDTH   = 2;
  localparam int IQ_DEPTH      = 8;

  typedef logic [$clog2(IQ_DEPTH)-1:0] iq_ptr_t;

  // Issue class used by dispatch to decide single vs dual issue
  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_MEM  = 2'd1,
    CLS_PRIV = 2'd2,
    CLS_CNT  = 2'd3
  } issue_cls_e;

  typedef struct packed {
    logic       valid;
    logic [31:0] pc;
    logic [31:0] instr;
    issue_cls_e cls;
    logic [4:0] rd;
  } id_dispatch_t;

endpackage

// File: rtl/instr_queue.sv
// Dual-ported decoded-instruction FIFO between the decoder and dispatch.
// Accepts up to two entries per cycle, presents the oldest two, pops 0/1/2.
module instr_queue
  import pipeline_types::*;
#(
  parameter int DEPTH         = IQ_DEPTH,
  parameter int DECODER_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  id_dispatch_t [DECODER_WIDTH-1:0]  enq_i,
  output logic                              enq_ready,
  output logic                              pause_iq,
  input  logic [DECODER_WIDTH-1:0]          deq_en,
  output id_dispatch_t [DECODER_WIDTH-1:0]  dispatch_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  id_dispatch_t mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          wr0_en, wr1_en;
  logic [PW-1:0] wr0_idx, wr1_idx;
  id_dispatch_t  wr0_data, wr1_data;
  logic [1:0]    n_enq, n_deq;

  // Intake readiness from registered occupancy only; no same-cycle pop credit
  always_comb begin
    enq_ready = (count_q <= CW'(DEPTH - 2));
    pause_iq  = !enq_ready && (enq_i[0].valid || enq_i[1].valid);
  end

  // Compact valid enqueue slots onto tail / tail+1 and count them
  always_comb begin
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_idx  = tail_q;
    wr1_idx  = tail_q + PW'(1);
    wr0_data = enq_i[0];
    wr1_data = enq_i[1];
    n_enq    = 2'd0;
    if (enq_ready && !rst && !flush) begin
      if (enq_i[0].valid && enq_i[1].valid) begin
        wr0_en = 1'b1;
        wr1_en = 1'b1;
        n_enq  = 2'd2;
      end else if (enq_i[0].valid) begin
        wr0_en = 1'b1;
        n_enq  = 2'd1;
      end else if (enq_i[1].valid) begin
        wr0_en   = 1'b1;
        wr0_data = enq_i[1];
        n_enq    = 2'd1;
      end
    end
  end

  // Decode pop mask (10 treated as no pop) and clamp to occupancy
  always_comb begin
    case (deq_en)
      2'b01:   n_deq = 2'd1;
      2'b11:   n_deq = 2'd2;
      default: n_deq = 2'd0;
    endcase
    if (CW'(n_deq) > count_q) n_deq = count_q[1:0];
    head_d  = head_q + PW'(n_deq);
    tail_d  = tail_q + PW'(n_enq);
    count_d = count_q + CW'(n_enq) - CW'(n_deq);
  end

  // Head presentation: valid bits come from occupancy, other fields pass through
  always_comb begin
    dispatch_o[0]       = mem_q[head_q];
    dispatch_o[1]       = mem_q[head_q + PW'(1)];
    dispatch_o[0].valid = (count_q >= CW'(1));
    dispatch_o[1].valid = (count_q >= CW'(2));
  end

  // Storage writes; contents need no reset
  always_ff @(posedge clk) begin
    if (wr0_en) mem_q[wr0_idx] <= wr0_data;
    if (wr1_en) mem_q[wr1_idx] <= wr1_data;
  end

  // Pointer and occupancy registers; reset beats flush beats normal update
  always_ff @(posedge clk) begin
    if (!rst) begin
      deq_mask_legal: assert (deq_en != 2'b10);
    end
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
